// File: rtl/ws2811_pkg.sv
// Shared types and helpers for the ws2811 frame scheduler.
package ws2811_pkg;

  typedef struct packed {
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
  } rgb_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } sched_state_t;

  localparam rgb_t BLANK_RGB = '0;

  // level 255 maps to a gain of 256, so full brightness is an exact pass-through
  function automatic logic [7:0] scale_chan(input logic [7:0] chan, input logic [7:0] level);
    return 8'((16'(chan) * (16'(level) + 16'd1)) >> 8);
  endfunction

endpackage

// File: rtl/ws2811_rgb_scale.sv
// Combinational per-channel brightness scaler: out = (chan * (level + 1)) >> 8.
module ws2811_rgb_scale
  import ws2811_pkg::*;
(
  input  logic [23:0] rgb_in,
  input  logic [7:0]  level,
  output logic [23:0] rgb_out
);

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      assign rgb_out[gi*8 +: 8] = scale_chan(rgb_in[gi*8 +: 8], level);
    end
  endgenerate

endmodule

// File: rtl/ws2811_frame_sched.sv
// Double-buffered colour store for the ws2811 driver; shadow commits to front on a frame boundary.
// Optional brightness scaling when WS2811_FRAME_SCHED_BRIGHTNESS_EN is defined.
module ws2811_frame_sched
  import ws2811_pkg::*;
#(
  parameter int NUM_LEDS    = 8,
  parameter int ADDR_W      = 3,
  parameter int FRAME_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   wr_valid,
  output logic                   wr_ready,
  input  logic [ADDR_W-1:0]      wr_addr,
  input  logic [7:0]             wr_red,
  input  logic [7:0]             wr_green,
  input  logic [7:0]             wr_blue,
  input  logic                   commit_valid,
  output logic                   commit_ready,
  input  logic [ADDR_W-1:0]      drv_address,
  output logic [7:0]             red_out,
  output logic [7:0]             green_out,
  output logic [7:0]             blue_out,
  output logic                   frame_done,
  output logic                   swapped,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   wr_err
`ifdef WS2811_FRAME_SCHED_BRIGHTNESS_EN
  ,
  input  logic [7:0]             brightness
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_LEDS - 1);

  sched_state_t           state_reg, state_next;
  rgb_t                   shadow_reg [NUM_LEDS];
  rgb_t                   front_reg  [NUM_LEDS];
  logic [ADDR_W-1:0]      prev_addr_reg;
  logic [FRAME_CNT_W-1:0] frame_cnt_reg;
  logic                   frame_done_reg;
  logic                   swapped_reg;
  logic                   wr_err_reg;

  logic boundary;
  logic wr_fire;
  logic wr_in_range;
  logic swap_en;
  rgb_t wr_rgb;
  rgb_t rd_rgb;
  rgb_t disp_rgb;

  assign boundary    = (prev_addr_reg == LAST_ADDR) && (drv_address == '0);
  assign wr_fire     = wr_valid && wr_ready;
  assign wr_in_range = 32'(wr_addr) < NUM_LEDS;
  assign wr_rgb      = '{red: wr_red, green: wr_green, blue: wr_blue};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // A commit taken in IDLE only arms PENDING, so a boundary in that same cycle is not used.
  always_comb begin
    state_next   = state_reg;
    wr_ready     = 1'b0;
    commit_ready = 1'b0;
    swap_en      = 1'b0;
    case (state_reg)
      IDLE: begin
        wr_ready     = 1'b1;
        commit_ready = 1'b1;
        if (commit_valid) begin
          state_next = PENDING;
        end
      end
      PENDING: begin
        if (boundary) begin
          swap_en    = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        shadow_reg[i] <= BLANK_RGB;
        front_reg[i]  <= BLANK_RGB;
      end
      prev_addr_reg  <= '0;
      frame_cnt_reg  <= '0;
      frame_done_reg <= 1'b0;
      swapped_reg    <= 1'b0;
      wr_err_reg     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_LEDS; i++) begin
        if (wr_fire && (wr_addr == ADDR_W'(i))) begin
          shadow_reg[i] <= wr_rgb;
        end
        if (swap_en) begin
          front_reg[i] <= shadow_reg[i];
        end
      end
      prev_addr_reg  <= drv_address;
      frame_done_reg <= boundary;
      swapped_reg    <= swap_en;
      if (boundary) begin
        frame_cnt_reg <= frame_cnt_reg + FRAME_CNT_W'(1);
      end
      if (wr_fire && !wr_in_range) begin
        wr_err_reg <= 1'b1;
      end
    end
  end

  // Out-of-range driver addresses fall through to blank.
  always_comb begin
    rd_rgb = BLANK_RGB;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (drv_address == ADDR_W'(i)) begin
        rd_rgb = front_reg[i];
      end
    end
  end

`ifdef WS2811_FRAME_SCHED_BRIGHTNESS_EN
  logic [7:0] level_reg;

  // Latched only at a swap so a brightness change never lands mid-frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_reg <= 8'hFF;
    end else if (swap_en) begin
      level_reg <= brightness;
    end
  end

  ws2811_rgb_scale u_scale (
    .rgb_in  (rd_rgb),
    .level   (level_reg),
    .rgb_out (disp_rgb)
  );
`else
  assign disp_rgb = rd_rgb;
`endif

  assign red_out    = disp_rgb.red;
  assign green_out  = disp_rgb.green;
  assign blue_out   = disp_rgb.blue;
  assign frame_done = frame_done_reg;
  assign swapped    = swapped_reg;
  assign frame_cnt  = frame_cnt_reg;
  assign wr_err     = wr_err_reg;

endmodule

// File: tb/tb_ws2811_frame_sched.sv
// Directed self-checking bench for ws2811_frame_sched (8-LED and 5-LED instances).
`timescale 1ns/1ps
module tb_ws2811_frame_sched;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic        reset;
  logic        wr_valid, wr_ready;
  logic [2:0]  wr_addr;
  logic [7:0]  wr_red, wr_green, wr_blue;
  logic        commit_valid, commit_ready;
  logic [2:0]  drv_address;
  logic [7:0]  red_out, green_out, blue_out;
  logic        frame_done, swapped, wr_err;
  logic [15:0] frame_cnt;

  logic        wr_valid5, wr_ready5;
  logic [2:0]  wr_addr5;
  logic [7:0]  wr_red5, wr_green5, wr_blue5;
  logic        commit_valid5, commit_ready5;
  logic [2:0]  drv5;
  logic [7:0]  red5, green5, blue5;
  logic        frame_done5, swapped5, wr_err5;
  logic [15:0] frame_cnt5;

`ifdef WS2811_FRAME_SCHED_BRIGHTNESS_EN
  logic [7:0]  brightness, brightness5;
`endif

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [2:0]  prev_m;
  logic [15:0] exp_cnt;

  ws2811_frame_sched #(.NUM_LEDS(8), .ADDR_W(3), .FRAME_CNT_W(16)) u_dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_red(wr_red), .wr_green(wr_green), .wr_blue(wr_blue),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
    .drv_address(drv_address),
    .red_out(red_out), .green_out(green_out), .blue_out(blue_out),
    .frame_done(frame_done), .swapped(swapped), .frame_cnt(frame_cnt), .wr_err(wr_err)
`ifdef WS2811_FRAME_SCHED_BRIGHTNESS_EN
    , .brightness(brightness)
`endif
  );

  ws2811_frame_sched #(.NUM_LEDS(5), .ADDR_W(3), .FRAME_CNT_W(16)) u_dut5 (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid5), .wr_ready(wr_ready5), .wr_addr(wr_addr5),
    .wr_red(wr_red5), .wr_green(wr_green5), .wr_blue(wr_blue5),
    .commit_valid(commit_valid5), .commit_ready(commit_ready5),
    .drv_address(drv5),
    .red_out(red5), .green_out(green5), .blue_out(blue5),
    .frame_done(frame_done5), .swapped(swapped5), .frame_cnt(frame_cnt5), .wr_err(wr_err5)
`ifdef WS2811_FRAME_SCHED_BRIGHTNESS_EN
    , .brightness(brightness5)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock with the 8-LED driver at address a; checks frame_done/frame_cnt against the boundary rule.
  task automatic step(input logic [2:0] a);
    logic exp_done;
    drv_address = a;
    @(posedge clk);
    #1;
    if (reset) begin
      exp_done = 1'b0;
      exp_cnt  = '0;
      prev_m   = '0;
    end else begin
      exp_done = (prev_m == 3'd7) && (a == 3'd0);
      if (exp_done) exp_cnt = exp_cnt + 16'd1;
      prev_m = a;
    end
    check("frame_done", frame_done, exp_done);
    check("frame_cnt", frame_cnt, exp_cnt);
    $display("step drv=%0d frame_done=%0b frame_cnt=%0d swapped=%0b", a, frame_done, frame_cnt, swapped);
  endtask

  task automatic peek(input logic [2:0] a);
    drv_address = a;
    #1;
  endtask

  task automatic peek5(input logic [2:0] a);
    drv5 = a;
    #1;
  endtask

  task automatic check_rgb(input string tag, input logic [23:0] exp);
    check(tag, {red_out, green_out, blue_out}, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    wr_valid = 0; wr_addr = 0; wr_red = 0; wr_green = 0; wr_blue = 0;
    commit_valid = 0; drv_address = 0;
    wr_valid5 = 0; wr_addr5 = 0; wr_red5 = 0; wr_green5 = 0; wr_blue5 = 0;
    commit_valid5 = 0; drv5 = 0;
`ifdef WS2811_FRAME_SCHED_BRIGHTNESS_EN
    brightness = 8'hFF; brightness5 = 8'hFF;
`endif
    prev_m = 0; exp_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state
    check("rst wr_ready", wr_ready, 1);
    check("rst commit_ready", commit_ready, 1);
    check("rst frame_cnt", frame_cnt, 0);
    check("rst frame_done", frame_done, 0);
    check("rst swapped", swapped, 0);
    check("rst wr_err", wr_err, 0);
    check_rgb("rst rgb", 24'h000000);

    // out-of-range write on the 5-LED instance
    check("d5 wr_ready", wr_ready5, 1);
    wr_valid5 = 1; wr_addr5 = 4; {wr_red5, wr_green5, wr_blue5} = 24'h404142;
    step(3'd0);
    check("d5 wr_err clear", wr_err5, 0);
    wr_addr5 = 5; {wr_red5, wr_green5, wr_blue5} = 24'hFFFFFF;
    step(3'd0);
    wr_valid5 = 0;
    check("d5 wr_err set", wr_err5, 1);
    check("d5 commit_ready", commit_ready5, 1);
    commit_valid5 = 1;
    step(3'd0);
    commit_valid5 = 0;
    drv5 = 4;
    step(3'd0);
    drv5 = 0;
    step(3'd0);
    check("d5 frame_done", frame_done5, 1);
    check("d5 swapped", swapped5, 1);
    check("d5 frame_cnt", frame_cnt5, 1);
    for (int a = 0; a < 8; a++) begin
      peek5(3'(a));
      check("d5 rgb", {red5, green5, blue5}, (a == 4) ? 24'h404142 : 24'h000000);
    end
    check("d5 wr_err sticky", wr_err5, 1);

    // two driver frames plus a non-boundary wrap; outputs stay blank
    for (int f = 0; f < 2; f++) begin
      for (int a = 0; a < 8; a++) begin
        step(3'(a));
        check("blank red", red_out, 0);
      end
    end
    step(3'd5);
    step(3'd0);

    // write LED3 then commit mid-frame
    step(3'd1); step(3'd2); step(3'd3);
    wr_valid = 1; wr_addr = 3; {wr_red, wr_green, wr_blue} = 24'hFFAA00;
    check("idle wr_ready", wr_ready, 1);
    step(3'd3);
    wr_valid = 0;
    check_rgb("shadow only", 24'h000000);
    commit_valid = 1;
    check("idle commit_ready", commit_ready, 1);
    step(3'd3);
    commit_valid = 0;
    check("pend wr_ready", wr_ready, 0);
    check("pend commit_ready", commit_ready, 0);
    for (int a = 4; a < 8; a++) step(3'(a));
    peek(3'd3);
    check_rgb("pre-swap rgb", 24'h000000);
    step(3'd0);
    check("swap pulse", swapped, 1);
    check("post-swap wr_ready", wr_ready, 1);
    peek(3'd3);
    check_rgb("post-swap rgb", 24'hFFAA00);
    step(3'd1);
    check("swap one cycle", swapped, 0);

    // host holds a write while a commit is pending
    commit_valid = 1;
    step(3'd1);
    commit_valid = 0;
    wr_valid = 1; wr_addr = 3; {wr_red, wr_green, wr_blue} = 24'h112233;
    check("held wr_ready", wr_ready, 0);
    for (int a = 2; a < 8; a++) step(3'(a));
    check("held wr_ready end", wr_ready, 0);
    step(3'd0);
    check("held swap", swapped, 1);
    check("held wr_ready free", wr_ready, 1);
    peek(3'd3);
    check_rgb("held front", 24'hFFAA00);
    step(3'd1);
    wr_valid = 0;
    for (int a = 2; a < 8; a++) step(3'(a));
    step(3'd0);
    check("no commit no swap", swapped, 0);
    peek(3'd3);
    check_rgb("no commit rgb", 24'hFFAA00);
    commit_valid = 1;
    step(3'd1);
    commit_valid = 0;
    for (int a = 2; a < 8; a++) step(3'(a));
    step(3'd0);
    check("second swap", swapped, 1);
    peek(3'd3);
    check_rgb("second rgb", 24'h112233);

    // commit accepted on the boundary cycle waits one more frame
    wr_valid = 1; wr_addr = 0; {wr_red, wr_green, wr_blue} = 24'h010203;
    step(3'd1);
    wr_valid = 0;
    for (int a = 2; a < 8; a++) step(3'(a));
    commit_valid = 1;
    check("edge commit_ready", commit_ready, 1);
    step(3'd0);
    commit_valid = 0;
    check("edge no swap", swapped, 0);
    check("edge pending", commit_ready, 0);
    peek(3'd0);
    check_rgb("edge rgb old", 24'h000000);
    for (int a = 1; a < 8; a++) step(3'(a));
    step(3'd0);
    check("edge late swap", swapped, 1);
    peek(3'd0);
    check_rgb("edge rgb new", 24'h010203);

    // reset while pending
    commit_valid = 1;
    step(3'd1);
    commit_valid = 0;
    check("rp pending", commit_ready, 0);
    step(3'd2);
    reset = 1;
    step(3'd3);
    reset = 0;
    check("rp commit_ready", commit_ready, 1);
    check("rp wr_ready", wr_ready, 1);
    check("rp swapped", swapped, 0);
    peek(3'd3);
    check_rgb("rp rgb3", 24'h000000);
    peek(3'd0);
    check_rgb("rp rgb0", 24'h000000);
    for (int a = 4; a < 8; a++) step(3'(a));
    step(3'd0);
    check("rp no swap", swapped, 0);
    peek(3'd0);
    check_rgb("rp rgb after", 24'h000000);

`ifdef WS2811_FRAME_SCHED_BRIGHTNESS_EN
    // brightness latched at the swap only
    wr_valid = 1; wr_addr = 3; {wr_red, wr_green, wr_blue} = 24'hFF8000;
    step(3'd1);
    wr_valid = 0;
    brightness = 8'd127;
    commit_valid = 1;
    step(3'd2);
    commit_valid = 0;
    for (int a = 3; a < 8; a++) step(3'(a));
    step(3'd0);
    peek(3'd3);
    check_rgb("bright 127", 24'h7F4000);
    brightness = 8'd0;
    for (int a = 1; a < 7; a++) step(3'(a));
    peek(3'd3);
    check_rgb("bright midframe", 24'h7F4000);
    commit_valid = 1;
    step(3'd7);
    commit_valid = 0;
    step(3'd0);
    check("bright swap", swapped, 1);
    peek(3'd3);
    check_rgb("bright 0", 24'h000000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
